// File: rtl/ex_flag_stage.sv
// Execute-to-memory boundary register: latches ALU result and writeback control,
// holds the architectural NZCV flags, and resolves CBZ/CBNZ/B.cond one cycle after the ALU.
module ex_flag_stage #(
  parameter int WIDTH = 64,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             negative,
  input  logic             zero,
  input  logic             overflow,
  input  logic             carry_out,
  input  logic             set_flags,
  input  logic             is_cbz,
  input  logic             is_cbnz,
  input  logic             is_bcond,
  input  logic [3:0]       cond,
  input  logic [REGW-1:0]  rd_in,
  input  logic             reg_write_in,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] result_q,
  output logic [REGW-1:0]  rd_q,
  output logic             reg_write_q,
  output logic             valid_q,
  output logic             branch_taken_q,
  output logic [3:0]       flags_q
);

  logic capture;
  logic accept;
  logic cond_true;
  logic taken;
  logic flag_n, flag_z, flag_c, flag_v;

  assign capture = !stall;
  assign accept  = capture && valid_in && !flush;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // B.cond reads the flags already in the register, never the ones arriving this cycle.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'd0:    cond_true = flag_z;
      4'd1:    cond_true = !flag_z;
      4'd2:    cond_true = flag_c;
      4'd3:    cond_true = !flag_c;
      4'd4:    cond_true = flag_n;
      4'd5:    cond_true = !flag_n;
      4'd6:    cond_true = flag_v;
      4'd7:    cond_true = !flag_v;
      4'd8:    cond_true = flag_c && !flag_z;
      4'd9:    cond_true = !(flag_c && !flag_z);
      4'd10:   cond_true = (flag_n == flag_v);
      4'd11:   cond_true = (flag_n != flag_v);
      4'd12:   cond_true = !flag_z && (flag_n == flag_v);
      4'd13:   cond_true = !(!flag_z && (flag_n == flag_v));
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    if (is_cbz)
      taken = zero;
    else if (is_cbnz)
      taken = !zero;
    else if (is_bcond)
      taken = cond_true;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q       <= '0;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      valid_q        <= 1'b0;
      branch_taken_q <= 1'b0;
      flags_q        <= 4'b0000;
    end else begin
      if (capture) begin
        valid_q        <= accept;
        result_q       <= alu_result;
        rd_q           <= rd_in;
        reg_write_q    <= accept && reg_write_in;
        branch_taken_q <= accept && taken;
      end else if (flush) begin
        // A flush during a stall kills the held instruction but leaves its data in place.
        valid_q        <= 1'b0;
        reg_write_q    <= 1'b0;
        branch_taken_q <= 1'b0;
      end
      if (accept && set_flags)
        flags_q <= {negative, zero, carry_out, overflow};
    end
  end

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed bench for ex_flag_stage: the driver queues hand-computed expectations,
// a monitor pops one per clock edge and compares the registered outputs.
module tb_ex_flag_stage;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic [63:0] alu_result;
  logic        negative, zero, overflow, carry_out;
  logic        set_flags;
  logic        is_cbz, is_cbnz, is_bcond;
  logic [3:0]  cond;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        stall, flush;
  logic [63:0] result_q;
  logic [4:0]  rd_q;
  logic        reg_write_q, valid_q, branch_taken_q;
  logic [3:0]  flags_q;

  ex_flag_stage #(.WIDTH(64), .REGW(5)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .alu_result(alu_result),
    .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
    .set_flags(set_flags), .is_cbz(is_cbz), .is_cbnz(is_cbnz), .is_bcond(is_bcond),
    .cond(cond), .rd_in(rd_in), .reg_write_in(reg_write_in), .stall(stall),
    .flush(flush), .result_q(result_q), .rd_q(rd_q), .reg_write_q(reg_write_q),
    .valid_q(valid_q), .branch_taken_q(branch_taken_q), .flags_q(flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [75:0] bits;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;
  logic [75:0] mon_act;

  function automatic logic [75:0] pack_out();
    return {valid_q, result_q, rd_q, reg_write_q, branch_taken_q, flags_q};
  endfunction

  // Monitor: one registered output set per edge.
  always @(posedge clk) begin
    #1;
    if (reset_n && sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_act = pack_out();
      checks++;
      if (mon_act !== mon_e.bits) begin
        errors++;
        $display("FAIL %s: got v=%0b res=%h rd=%0d rw=%0b br=%0b fl=%b expected v=%0b res=%h rd=%0d rw=%0b br=%0b fl=%b",
                 mon_e.nm, mon_act[75], mon_act[74:11], mon_act[10:6], mon_act[5], mon_act[4], mon_act[3:0],
                 mon_e.bits[75], mon_e.bits[74:11], mon_e.bits[10:6], mon_e.bits[5], mon_e.bits[4], mon_e.bits[3:0]);
      end else begin
        $display("txn %s ok", mon_e.nm);
      end
    end
  end

  task automatic clr();
    valid_in = 0; alu_result = '0; negative = 0; zero = 0; overflow = 0; carry_out = 0;
    set_flags = 0; is_cbz = 0; is_cbnz = 0; is_bcond = 0; cond = '0; rd_in = '0;
    reg_write_in = 0; stall = 0; flush = 0;
  endtask

  // Queue the expectation for the coming edge, then advance past it and clear inputs.
  task automatic cyc(input string nm, input logic ev, input logic [63:0] er, input logic [4:0] erd,
                     input logic erw, input logic ebr, input logic [3:0] efl);
    exp_t e;
    e.nm   = nm;
    e.bits = {ev, er, erd, erw, ebr, efl};
    sb.push_back(e);
    @(posedge clk);
    #2;
    clr();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
    end
  endtask

  task automatic check_rst(input string nm);
    checks++;
    if (pack_out() !== 76'd0) begin
      errors++;
      $display("FAIL %s: got outputs %h expected 0", nm, pack_out());
    end else begin
      $display("txn %s ok", nm);
    end
  endtask

  initial begin
    clr();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 check_rst("reset_init");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Idle cycles: invalid instructions never touch flags, even with set_flags.
    cyc("idle0", 0, 64'h0, 0, 0, 0, 4'b0000);
    set_flags = 1; negative = 1;
    cyc("idle1", 0, 64'h0, 0, 0, 0, 4'b0000);
    cyc("idle2", 0, 64'h0, 0, 0, 0, 4'b0000);

    // SUBS equal -> Z and C set, then B.EQ / B.NE / B.HS / B.LO / B.HI.
    valid_in = 1; zero = 1; carry_out = 1; set_flags = 1; rd_in = 3; reg_write_in = 1;
    cyc("subs", 1, 64'h0, 3, 1, 0, 4'b0110);
    valid_in = 1; is_bcond = 1; cond = 4'd0; alu_result = 64'h5;
    cyc("b_eq", 1, 64'h5, 0, 0, 1, 4'b0110);
    valid_in = 1; is_bcond = 1; cond = 4'd1;
    cyc("b_ne", 1, 64'h0, 0, 0, 0, 4'b0110);
    valid_in = 1; is_bcond = 1; cond = 4'd2;
    cyc("b_hs", 1, 64'h0, 0, 0, 1, 4'b0110);
    valid_in = 1; is_bcond = 1; cond = 4'd3;
    cyc("b_lo", 1, 64'h0, 0, 0, 0, 4'b0110);
    valid_in = 1; is_bcond = 1; cond = 4'd8;
    cyc("b_hi", 1, 64'h0, 0, 0, 0, 4'b0110);

    // Signed conditions with N=1, V=0.
    valid_in = 1; set_flags = 1; negative = 1; alu_result = 64'h8000_0000_0000_0000; rd_in = 1; reg_write_in = 1;
    cyc("load_n", 1, 64'h8000_0000_0000_0000, 1, 1, 0, 4'b1000);
    valid_in = 1; is_bcond = 1; cond = 4'd10;
    cyc("b_ge", 1, 64'h0, 0, 0, 0, 4'b1000);
    valid_in = 1; is_bcond = 1; cond = 4'd11;
    cyc("b_lt", 1, 64'h0, 0, 0, 1, 4'b1000);
    valid_in = 1; is_bcond = 1; cond = 4'd12;
    cyc("b_gt", 1, 64'h0, 0, 0, 0, 4'b1000);
    valid_in = 1; is_bcond = 1; cond = 4'd13;
    cyc("b_le", 1, 64'h0, 0, 0, 1, 4'b1000);
    valid_in = 1; is_bcond = 1; cond = 4'd15;
    cyc("b_nv", 1, 64'h0, 0, 0, 1, 4'b1000);
    valid_in = 1; is_bcond = 0; cond = 4'd14;
    cyc("no_branch", 1, 64'h0, 0, 0, 0, 4'b1000);

    // CBZ / CBNZ with live ALU flags but no set_flags.
    valid_in = 1; is_cbz = 1; zero = 1; carry_out = 1; overflow = 1;
    cyc("cbz_t", 1, 64'h0, 0, 0, 1, 4'b1000);
    valid_in = 1; is_cbz = 1; zero = 0; alu_result = 64'h7; negative = 1;
    cyc("cbz_nt", 1, 64'h7, 0, 0, 0, 4'b1000);
    valid_in = 1; is_cbnz = 1; zero = 0; alu_result = 64'h7; overflow = 1;
    cyc("cbnz_t", 1, 64'h7, 0, 0, 1, 4'b1000);
    valid_in = 1; is_cbz = 1; is_cbnz = 1; zero = 1;
    cyc("cbz_prio", 1, 64'h0, 0, 0, 1, 4'b1000);

    // Stall holds everything, then the held instruction is captured.
    valid_in = 1; zero = 1; carry_out = 1; set_flags = 1; rd_in = 2; reg_write_in = 1;
    cyc("flags_0110", 1, 64'h0, 2, 1, 0, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      valid_in = 1; set_flags = 1; negative = 1; zero = 1; carry_out = 1;
      alu_result = 64'hDEAD; rd_in = 9; reg_write_in = 1; stall = (i < 2);
      if (i < 2) cyc("stall_hold", 1, 64'h0, 2, 1, 0, 4'b0110);
      else       cyc("stall_release", 1, 64'hDEAD, 9, 1, 0, 4'b1110);
    end

    // Flush alone: data captured, instruction killed, flags untouched.
    valid_in = 1; flush = 1; set_flags = 1; is_cbz = 1; zero = 1; reg_write_in = 1;
    alu_result = 64'h1234; rd_in = 4;
    cyc("flush", 0, 64'h1234, 4, 0, 0, 4'b1110);
    valid_in = 1; is_cbz = 1; zero = 1; reg_write_in = 1; rd_in = 5;
    cyc("cbz_rw", 1, 64'h0, 5, 1, 1, 4'b1110);
    // Flush with stall: kill the held instruction, keep its data.
    valid_in = 1; flush = 1; stall = 1; set_flags = 1; is_cbz = 1; zero = 1; reg_write_in = 1;
    alu_result = 64'h1234; rd_in = 4;
    cyc("flush_stall", 0, 64'h0, 5, 0, 0, 4'b1110);
    valid_in = 1; alu_result = 64'hABC; rd_in = 7; reg_write_in = 1;
    cyc("plain", 1, 64'hABC, 7, 1, 0, 4'b1110);
    drain();

    // Asynchronous reset mid-cycle, held across an edge with a live instruction.
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_rst("reset_async");
    valid_in = 1; set_flags = 1; negative = 1; alu_result = 64'h99; rd_in = 6; reg_write_in = 1;
    @(posedge clk);
    #1 check_rst("reset_held");
    @(negedge clk);
    clr();
    reset_n = 1'b1;
    cyc("post_reset", 0, 64'h0, 0, 0, 0, 4'b0000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_flag_stage.md
# ex_flag_stage

Execute-to-memory boundary stage that sits directly downstream of the 64-bit ALU. It registers the ALU result and destination-register control, and holds the architectural NZCV condition-flag register, written only by flag-setting instructions. It resolves CBZ, CBNZ and B.cond branch decisions one cycle after the ALU produces its outputs. It supports pipeline stall and flush.

## Interface
Parameters:
- `WIDTH`, 64: datapath width; must match the ALU result width.
- `REGW`, 5: destination register index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `valid_in` in 1: ALU outputs and controls carry a live instruction this cycle.
- `alu_result` in WIDTH: ALU `result`.
- `negative`, `zero`, `overflow`, `carry_out` in 1 each: ALU flags for this instruction.
- `set_flags` in 1: instruction is flag-setting (ADDS, SUBS, ANDS, CMP).
- `is_cbz`, `is_cbnz`, `is_bcond` in 1 each: branch type. At most one is set; if several are set, priority is cbz > cbnz > bcond.
- `cond` in 4: B.cond condition code, ARM encoding.
- `rd_in` in REGW; `reg_write_in` in 1: writeback control.
- `stall` in 1: hold all state this cycle.
- `flush` in 1: kill the instruction being captured this cycle.
- `result_q` out WIDTH; `rd_q` out REGW; `reg_write_q` out 1: registered writeback data and control.
- `valid_q` out 1: registered instruction valid.
- `branch_taken_q` out 1: registered branch decision.
- `flags_q` out 4: architectural flags, ordered {N,Z,C,V}.

## Operation
- Capture condition: `capture = !stall`. `accept = capture && valid_in && !flush`.
- Pipeline register on `capture`:
  - `valid_q <= accept`.
  - `result_q`, `rd_q` load unconditionally.
  - `reg_write_q <= accept && reg_write_in`.
- Flush has priority over stall for valid: `flush && stall` forces `valid_q <= 0`, `reg_write_q <= 0` and `branch_taken_q <= 0`. All other registers hold.
- Flag register: on `accept && set_flags`, `flags_q <= {negative, zero, carry_out, overflow}`. Otherwise `flags_q` holds. Stalled and flushed instructions never modify flags.
- Branch decision, registered on `capture`, forced to 0 unless `accept`:
  - CBZ: taken when `zero` (the ALU passes Rt through with pass-B, so `zero` reflects Rt).
  - CBNZ: taken when `!zero`.
  - B.cond: evaluates `cond` against the current `flags_q` value, i.e. pre-update. A set_flags+bcond combination is not legal; if it occurs, the old flags are used.
- B.cond truth table (N,Z,C,V taken from `flags_q`):
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C.
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !(C&!Z).
  - 10 GE N==V; 11 LT N!=V.
  - 12 GT !Z&(N==V); 13 LE !(GT).
  - 14 AL 1; 15 NV 1.
- Back-to-back: when a flag-setting instruction in cycle t is followed by a B.cond in cycle t+1, the B.cond sees the flags written at the t edge. No bypass is needed.

## Timing
- Reset (`reset_n` low, asynchronous): every output goes to 0 immediately, including `flags_q = 4'b0000`, `valid_q`, `branch_taken_q`, `result_q`, `rd_q` and `reg_write_q`. The outputs stay 0 until the first rising edge with `reset_n` high.
- Reset asserted mid-stall or mid-flush: reset wins, and the in-flight instruction is lost.
- Latency: 1 cycle from ALU inputs to all `_q` outputs and to the flags update.
- Throughput: 1 instruction per cycle when `stall` is low.
- Stall: every output holds its value for as many cycles as `stall` is high. Inputs presented during a stall are ignored; upstream must hold them.
- `flags_q` changes only on a rising edge with `accept && set_flags`.

## Test plan
- Reset and hold: assert `reset_n=0` mid-cycle → all outputs 0 asynchronously. Release, then drive `valid_in=0` for 3 cycles → `valid_q=0`, `flags_q=0000`.
- SUBS then B.EQ: cycle 1 drives `alu_result=0`, `zero=1`, `carry_out=1`, `set_flags=1` → `flags_q=0110`, `valid_q=1`. Cycle 2 drives `is_bcond=1`, `cond=0` → `branch_taken_q=1`. Repeat with `cond=1` → 0.
- Signed conditions: load flags N=1, V=0 → GE (10) not taken, LT (11) taken, GT (12) not taken, LE (13) taken.
- CBZ/CBNZ: `is_cbz=1` with `zero=1` → taken. `is_cbnz=1` with `zero=0` → taken. Neither case changes `flags_q`, even with nonzero ALU flags and `set_flags=0`.
- Stall: flags = 0110, then `stall=1` for 2 cycles with `set_flags=1`, `negative=1`, `result=64'hDEAD` → all outputs and flags hold. Release → capture occurs, giving `flags_q={1,...}` and `result_q=64'hDEAD`.
- Flush: `flush=1` with `valid_in=1`, `set_flags=1`, `is_cbz=1`, `zero=1`, `reg_write_in=1` → `valid_q=0`, `branch_taken_q=0`, `reg_write_q=0`, `flags_q` unchanged. Repeat with `flush=1` and `stall=1` together → same result.
